log_dump: RTL
=============

LOG_DUMP -- requirements
Module: log_dump

Interface
REQ-001 Parameter DEPTH, default 32768; number of 32-bit log words read out per dump.
REQ-002 Parameter ADDR_W, default 15; read-address width, with 2^ADDR_W >= DEPTH.
REQ-003 clockdsp  in  1  single clock; all logic on its rising edge.
REQ-004 soft_reset  in  1  synchronous, active-high reset.
REQ-005 dump_start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
REQ-006 dump_abort  in  1  level; terminates an active dump.
REQ-007 log_full  in  1  log memory full flag from the logger.
REQ-008 rd_addr  out  ADDR_W  read address to the log memory port B.
REQ-009 rd_data  in  32  log memory read data; valid exactly 1 cycle after rd_addr is presented.
REQ-010 tx_data  out  8  byte stream to the serial transmitter.
REQ-011 tx_valid  out  1  tx_data valid.
REQ-012 tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 dump_done  out  1  one-cycle pulse on completion or abort.

Function
REQ-015 FSM states: IDLE, ADDR, CAPT, SEND, DONE.
REQ-016 IDLE -> ADDR on dump_start=1 and log_full=1; dump_start with log_full=0 is ignored.
REQ-017 On IDLE -> ADDR, the word counter and rd_addr are cleared to 0.
REQ-018 ADDR: rd_addr holds the current word address; next state is CAPT.
REQ-019 CAPT: a 32-bit shift register loads rd_data; the byte index is cleared; next state is SEND.
REQ-020 SEND: tx_valid=1; tx_data is the current byte, least-significant byte first (bits 7:0, 15:8, 23:16, 31:24).
REQ-021 tx_data and tx_valid are driven from registers; tx_data is stable while tx_valid=1 and tx_ready=0.
REQ-022 Each handshake advances the byte index; on the 4th handshake: if word counter = DEPTH-1, go to DONE; otherwise increment the counter and rd_addr and return to ADDR.
REQ-023 Per-word minimum latency: 2 cycles (ADDR, CAPT), then 4 accepted bytes; tx_valid is low during ADDR and CAPT.
REQ-024 DONE: dump_done=1 for exactly one cycle, then go to IDLE.
REQ-025 dump_abort=1 in ADDR, CAPT or SEND: next state is DONE; tx_valid drops the following cycle; a byte handshaking in the same cycle counts as sent and no further bytes follow.
REQ-026 dump_start while busy=1 is ignored.
REQ-027 The word counter is ADDR_W+1 bits wide; no wrap-around occurs because the terminal compare is against DEPTH-1.
REQ-028 rd_addr changes only on entry to ADDR.

Reset
REQ-029 soft_reset=1 forces IDLE from any state, including mid-byte, with no dump_done pulse.
REQ-030 Reset values: rd_addr=0, tx_data=0, tx_valid=0, busy=0, dump_done=0, counter=0, shift register=0.
REQ-031 soft_reset has priority over dump_start and dump_abort in the same cycle.

Structure
REQ-032 The FSM state encoding and the bytes-per-word constant (4) live in the shared dsp package, alongside the logger FSM encodings.
REQ-033 One sub-module: the existing mod_m_counter (M=DEPTH) serves as the word counter; its max output is the terminal flag; no other sub-modules are used.
REQ-034 The log memory is external; this block only drives its port B address.

Verification
REQ-035 DEPTH=4, RAM words 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; log_full=1; pulse start; tx_ready=1 -> bytes 0x01..0x10 in order, exactly 16 handshakes, then one dump_done pulse.
REQ-036 Same setup, tx_ready toggling every other cycle -> identical byte sequence; tx_data stable during stalls.
REQ-037 log_full=0 and start pulse -> busy stays 0; no tx_valid; no dump_done.
REQ-038 dump_abort asserted after the 6th handshake -> tx_valid low the next cycle; dump_done pulse; busy low after; a subsequent start re-dumps from address 0.
REQ-039 soft_reset asserted mid-SEND -> all outputs reach reset values the next cycle; no dump_done pulse.
REQ-040 Start pulse while busy=1 -> byte sequence unaffected; total handshakes remain 4*DEPTH.

Source files
------------

// File: rtl/log_dump_pkg.sv
// Shared DSP package: dump and logger FSM encodings plus byte helpers for the log path.
package log_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CAPT,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    typedef enum logic [1:0] {
        LOG_IDLE,
        LOG_ARMED,
        LOG_CAPTURE,
        LOG_FULL
    } log_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;

    // Byte lane idx of a 32-bit word, lane 0 = bits 7:0.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/log_dump_counter.sv
// Modulo-M counter with synchronous clear/enable; max_tick flags the terminal count M-1.
module mod_m_counter #(
    parameter int unsigned M = 10,
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] q,
    output logic         max_tick
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= (r_q == N'(M - 1)) ? '0 : r_q + 1'b1;
        end
    end

    assign q        = r_q;
    assign max_tick = (r_q == N'(M - 1));

endmodule

// File: rtl/log_dump.sv
// Streams DEPTH 32-bit log words from external memory port B as LSB-first bytes
// over a valid/ready byte link, with abort and synchronous soft reset.
module log_dump
    import log_dump_pkg::*;
#(
    parameter int unsigned DEPTH  = 32768,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clockdsp,
    input  logic              soft_reset,
    input  logic              dump_start,
    input  logic              dump_abort,
    input  logic              log_full,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              dump_done
);

    dump_state_t r_state;
    dump_state_t w_next;

    logic [31:0]     r_shift;
    logic [1:0]      r_byte_idx;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;

    logic [ADDR_W:0] w_cnt_q;
    logic            w_cnt_max;
    logic            w_cnt_clr;
    logic            w_cnt_en;
    logic            w_hs;
    logic            w_last_byte;
    logic            w_last_word;

    assign w_hs        = r_tx_valid && tx_ready;
    assign w_last_byte = (r_byte_idx == 2'(BYTES_PER_WORD - 1));
    // The counter never passes DEPTH-1; the MSB test only hardens the terminal compare.
    assign w_last_word = w_cnt_max || w_cnt_q[ADDR_W];

    mod_m_counter #(
        .M (DEPTH),
        .N (ADDR_W + 1)
    ) u_word_cnt (
        .clk      (clockdsp),
        .reset    (soft_reset),
        .clr      (w_cnt_clr),
        .en       (w_cnt_en),
        .q        (w_cnt_q),
        .max_tick (w_cnt_max)
    );

    always_ff @(posedge clockdsp) begin
        if (soft_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (dump_start && log_full) begin
                    w_next    = ST_ADDR;
                    w_cnt_clr = 1'b1;
                end
            end
            ST_ADDR: w_next = dump_abort ? ST_DONE : ST_CAPT;
            ST_CAPT: w_next = dump_abort ? ST_DONE : ST_SEND;
            ST_SEND: begin
                if (dump_abort) begin
                    w_next = ST_DONE;
                end else if (w_hs && w_last_byte) begin
                    if (w_last_word) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next   = ST_ADDR;
                        w_cnt_en = 1'b1;
                    end
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clockdsp) begin
        if (soft_reset) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_CAPT: begin
                    r_shift    <= rd_data;
                    r_byte_idx <= '0;
                    r_tx_data  <= rd_data[7:0];
                    r_tx_valid <= !dump_abort;
                end
                ST_SEND: begin
                    if (dump_abort) begin
                        r_tx_valid <= 1'b0;
                    end else if (w_hs) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte) begin
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_tx_data <= word_byte(r_shift, r_byte_idx + 2'd1);
                        end
                    end
                end
                default: r_tx_valid <= 1'b0;
            endcase
        end
    end

    assign rd_addr   = w_cnt_q[ADDR_W-1:0];
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign busy      = (r_state != ST_IDLE);
    assign dump_done = (r_state == ST_DONE);

endmodule
